// File: rtl/operand_pkg.sv
// Shared types and constants for the operand fetch stage.
// The register-file bypass is enabled by defining OPERAND_FETCH_BYPASS_EN.
package operand_pkg;

  localparam int unsigned N    = 16;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = $clog2(NREG);

  typedef enum logic [1:0] {
    StIdle,
    StRdA,
    StRdB,
    StHold
  } state_e;

  typedef enum logic [1:0] {
    ShNone = 2'b00,
    ShLsl  = 2'b01,
    ShLsr  = 2'b10,
    ShAsr  = 2'b11
  } shift_e;

  // One-bit shift of operand B; the shifted-out bit is dropped.
  function automatic logic [N-1:0] shift_op(input logic [N-1:0] x, input shift_e op);
    logic [N-1:0] r;
    unique case (op)
      ShNone:  r = x;
      ShLsl:   r = {x[N-2:0], 1'b0};
      ShLsr:   r = {1'b0, x[N-1:1]};
      ShAsr:   r = {x[N-1], x[N-1:1]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Command, writeback and operand handshake bundle of the operand fetch stage.
// The master modport is the controller/ALU side; the slave modport is the stage.
interface operand_fetch_if;
  import operand_pkg::*;

  logic          start;
  logic          ready;
  logic [AW-1:0] rn;
  logic [AW-1:0] rm;
  logic [1:0]    shift;
  logic          asel;
  logic          bsel;
  logic [N-1:0]  sximm5;
  logic          write;
  logic [AW-1:0] wnum;
  logic [N-1:0]  wdata;
  logic          valid;
  logic          accept;
  logic [N-1:0]  ain;
  logic [N-1:0]  bin;

  modport master (
    output start, rn, rm, shift, asel, bsel, sximm5, write, wnum, wdata, accept,
    input  ready, valid, ain, bin
  );

  modport slave (
    input  start, rn, rm, shift, asel, bsel, sximm5, write, wnum, wdata, accept,
    output ready, valid, ain, bin
  );

endinterface

// File: rtl/reg_file.sv
// NREG x N register file: one combinational read port, one synchronous write port.
// With OPERAND_FETCH_BYPASS_EN defined, a same-cycle write to the read address is forwarded.
module reg_file
  import operand_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] raddr_i,
  output logic [N-1:0]  rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i
);

  logic [N-1:0] mem_q [NREG];

  // Storage: synchronous clear, write ignored while in reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port, optionally forwarding the in-flight write.
  always_comb begin
`ifdef OPERAND_FETCH_BYPASS_EN
    rdata_o = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
`else
    rdata_o = mem_q[raddr_i];
`endif
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads up to two registers through one port, shifts B,
// applies the zero/immediate selects and holds Ain/Bin until the ALU accepts.
// Optional forwarding of same-cycle writes: define OPERAND_FETCH_BYPASS_EN.
module operand_fetch
  import operand_pkg::*;
(
  input logic             clk_i,
  input logic             rst_ni,
  operand_fetch_if.slave  bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] rn_q, rn_d, rm_q, rm_d;
  shift_e        shift_q, shift_d;
  logic          asel_q, asel_d, bsel_q, bsel_d;
  logic [N-1:0]  imm_q, imm_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [N-1:0]  ain_q, ain_d, bin_q, bin_d;

  logic [AW-1:0] raddr;
  logic [N-1:0]  rdata;
  logic          asel_eff, bsel_eff;
  logic [N-1:0]  imm_eff;

  // Single read port serves operand A in RD_A and operand B otherwise.
  always_comb begin
    raddr = (state_q == StRdA) ? rn_q : rm_q;
  end

  reg_file u_reg_file (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .raddr_i (raddr),
    .rdata_o (rdata),
    .we_i    (bus.write),
    .waddr_i (bus.wnum),
    .wdata_i (bus.wdata)
  );

  // Next-state, command capture, operand loads and output-register update.
  always_comb begin
    state_d  = state_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    shift_d  = shift_q;
    asel_d   = asel_q;
    bsel_d   = bsel_q;
    imm_d    = imm_q;
    a_d      = a_q;
    b_d      = b_q;
    ain_d    = ain_q;
    bin_d    = bin_q;
    // Selects in force for this cycle: fresh inputs when capturing, else the command.
    asel_eff = asel_q;
    bsel_eff = bsel_q;
    imm_eff  = imm_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          rn_d     = bus.rn;
          rm_d     = bus.rm;
          shift_d  = shift_e'(bus.shift);
          asel_d   = bus.asel;
          bsel_d   = bus.bsel;
          imm_d    = bus.sximm5;
          asel_eff = bus.asel;
          bsel_eff = bus.bsel;
          imm_eff  = bus.sximm5;
          if (!bus.asel) begin
            state_d = StRdA;
          end else if (!bus.bsel) begin
            state_d = StRdB;
          end else begin
            state_d = StHold;
          end
        end
      end
      StRdA: begin
        a_d     = rdata;
        state_d = bsel_q ? StHold : StRdB;
      end
      StRdB: begin
        b_d     = shift_op(rdata, shift_q);
        state_d = StHold;
      end
      StHold: begin
        if (bus.accept) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Load the presented operands once, on entry to HOLD, so they stay frozen there.
    if ((state_d == StHold) && (state_q != StHold)) begin
      ain_d = asel_eff ? '0 : a_d;
      bin_d = bsel_eff ? imm_eff : b_d;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= ShNone;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ain_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      shift_q <= shift_d;
      asel_q  <= asel_d;
      bsel_q  <= bsel_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ain_q   <= ain_d;
      bin_q   <= bin_d;
    end
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    bus.ready = (state_q == StIdle);
    bus.valid = (state_q == StHold);
    bus.ain   = ain_q;
    bus.bin   = bin_q;
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized commands
// with random writeback traffic, checked against a register-array reference model.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [15:0] mdl [8];

  operand_fetch_if ifc ();

  operand_fetch u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [1:0] op);
    int unsigned v;
    v = x;
    case (op)
      2'd0:    return x;
      2'd1:    return 16'((v * 2) % 65536);
      2'd2:    return 16'(v / 2);
      default: return 16'(v / 2 + ((v >= 32768) ? 32768 : 0));
    endcase
  endfunction

  // Value a register read sees in the current cycle, given the write being driven now.
  function automatic logic [15:0] rd_model(input logic [2:0] r);
    if (BYP && ifc.write && (ifc.wnum == r)) return ifc.wdata;
    return mdl[r];
  endfunction

  // One clock edge; the model commits whatever write was driven into that edge.
  task automatic tick();
    logic        w;
    logic [2:0]  n;
    logic [15:0] d;
    logic        r;
    w = ifc.write;
    n = ifc.wnum;
    d = ifc.wdata;
    r = rst_n;
    @(posedge clk);
    #1;
    if (!r) begin
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
    end else if (w) begin
      mdl[n] = d;
    end
  endtask

  task automatic idle_inputs();
    ifc.start  = 1'b0;
    ifc.rn     = 3'd0;
    ifc.rm     = 3'd0;
    ifc.shift  = 2'd0;
    ifc.asel   = 1'b0;
    ifc.bsel   = 1'b0;
    ifc.sximm5 = 16'h0;
    ifc.write  = 1'b0;
    ifc.wnum   = 3'd0;
    ifc.wdata  = 16'h0;
    ifc.accept = 1'b0;
  endtask

  // Random writes and stray start pulses with garbage fields; start must be ignored here.
  task automatic drive_noise(input bit rnd);
    if (rnd) begin
      ifc.write  = 1'($urandom_range(0, 1));
      ifc.wnum   = 3'($urandom);
      ifc.wdata  = 16'($urandom);
      ifc.start  = 1'($urandom_range(0, 1));
      ifc.rn     = 3'($urandom);
      ifc.rm     = 3'($urandom);
      ifc.shift  = 2'($urandom);
      ifc.asel   = 1'($urandom);
      ifc.bsel   = 1'($urandom);
      ifc.sximm5 = 16'($urandom);
    end else begin
      ifc.write = 1'b0;
      ifc.start = 1'b0;
    end
  endtask

  task automatic wr(input logic [2:0] num, input logic [15:0] data);
    ifc.write = 1'b1;
    ifc.wnum  = num;
    ifc.wdata = data;
    tick();
    ifc.write = 1'b0;
  endtask

  // Issue one command and run it to acceptance; returns observations and model expectations.
  task automatic do_cmd(
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [1:0]  sh,
    input  logic        as,
    input  logic        bs,
    input  logic [15:0] imm,
    input  bit          rnd,
    input  bit          start_on_accept,
    input  int          hold,
    input  bit          fw,
    input  logic [2:0]  fw_num,
    input  logic [15:0] fw_data,
    output int          lat,
    output logic [15:0] ain,
    output logic [15:0] bin,
    output logic [15:0] exp_a,
    output logic [15:0] exp_b,
    output bit          stable,
    output logic        rdy1,
    output logic        rdy2
  );
    logic [15:0] a_raw;
    logic [15:0] b_raw;
    int          b_cyc;
    int          nh;
    a_raw = 16'h0;
    b_raw = 16'h0;
    b_cyc = as ? 1 : 2;
    drive_noise(rnd);
    ifc.start  = 1'b1;
    ifc.rn     = rn;
    ifc.rm     = rm;
    ifc.shift  = sh;
    ifc.asel   = as;
    ifc.bsel   = bs;
    ifc.sximm5 = imm;
    ifc.accept = 1'b0;
    tick();
    lat = 1;
    while (!ifc.valid && lat < 12) begin
      drive_noise(rnd);
      ifc.accept = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (fw && lat == 1) begin
        ifc.write = 1'b1;
        ifc.wnum  = fw_num;
        ifc.wdata = fw_data;
      end
      if (lat == 1 && !as) a_raw = rd_model(rn);
      if (lat == b_cyc && !bs) b_raw = ref_shift(rd_model(rm), sh);
      tick();
      lat++;
    end
    exp_a  = as ? 16'h0 : a_raw;
    exp_b  = bs ? imm : b_raw;
    ain    = ifc.ain;
    bin    = ifc.bin;
    stable = 1'b1;
    nh     = (hold < 0) ? $urandom_range(0, 3) : hold;
    for (int i = 0; i < nh; i++) begin
      drive_noise(rnd);
      ifc.accept = 1'b0;
      tick();
      if (!ifc.valid || ifc.ain !== ain || ifc.bin !== bin) stable = 1'b0;
    end
    drive_noise(rnd);
    ifc.start  = start_on_accept;
    ifc.accept = 1'b1;
    tick();
    ifc.accept = 1'b0;
    ifc.start  = 1'b0;
    ifc.write  = 1'b0;
    rdy1 = ifc.ready;
    tick();
    rdy2 = ifc.ready;
  endtask

  // Shared result holders for the scenario tasks.
  int          lat;
  logic [15:0] ain, bin, ea, eb;
  bit          stb;
  logic        r1, r2;

  task automatic test_reset();
    idle_inputs();
    rst_n      = 1'b0;
    ifc.start  = 1'b1;
    ifc.write  = 1'b1;
    ifc.wnum   = 3'd3;
    ifc.wdata  = 16'hDEAD;
    tick();
    tick();
    rst_n = 1'b1;
    idle_inputs();
    n_vec++;
    if (ifc.ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready got %b want 1", ifc.ready);
    end
    n_vec++;
    if (ifc.valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid got %b want 0", ifc.valid);
    end
    n_vec++;
    if (ifc.ain !== 16'h0 || ifc.bin !== 16'h0) begin
      n_err++; $display("FAIL reset_operands got %h/%h want 0000/0000", ifc.ain, ifc.bin);
    end
    for (int i = 0; i < 8; i += 2) begin
      do_cmd(3'(i), 3'(i + 1), 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 0, 1'b0, 3'd0, 16'h0,
             lat, ain, bin, ea, eb, stb, r1, r2);
      n_vec++;
      if (ain !== 16'h0 || bin !== 16'h0) begin
        n_err++; $display("FAIL reset_regs R%0d/R%0d got %h/%h want 0000/0000", i, i + 1, ain, bin);
      end
    end
  endtask

  task automatic test_full_read();
    wr(3'd2, 16'h1234);
    wr(3'd5, 16'h8001);
    do_cmd(3'd2, 3'd5, 2'b11, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4, 1'b0, 3'd0, 16'h0,
           lat, ain, bin, ea, eb, stb, r1, r2);
    n_vec++;
    if (lat !== 3) begin n_err++; $display("FAIL full_latency got %0d want 3", lat); end
    n_vec++;
    if (ain !== 16'h1234) begin n_err++; $display("FAIL full_ain got %h want 1234", ain); end
    n_vec++;
    if (bin !== 16'hC000) begin n_err++; $display("FAIL full_bin_asr got %h want c000", bin); end
    n_vec++;
    if (!stb) begin n_err++; $display("FAIL full_hold_stable got 0 want 1"); end
  endtask

  task automatic test_imm_only();
    do_cmd(3'd7, 3'd7, 2'b01, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1, 1'b0, 3'd0, 16'h0,
           lat, ain, bin, ea, eb, stb, r1, r2);
    n_vec++;
    if (lat !== 1) begin n_err++; $display("FAIL imm_latency got %0d want 1", lat); end
    n_vec++;
    if (ain !== 16'h0 || bin !== 16'hFFFE) begin
      n_err++; $display("FAIL imm_operands got %h/%h want 0000/fffe", ain, bin);
    end
    n_vec++;
    if (r1 !== 1'b1 || r2 !== 1'b1) begin
      n_err++; $display("FAIL start_on_accept_ignored ready got %b%b want 11", r1, r2);
    end
  endtask

  task automatic test_shift();
    wr(3'd3, 16'h00F0);
    do_cmd(3'd0, 3'd3, 2'b01, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0, 3'd0, 16'h0,
           lat, ain, bin, ea, eb, stb, r1, r2);
    n_vec++;
    if (lat !== 2) begin n_err++; $display("FAIL shl_latency got %0d want 2", lat); end
    n_vec++;
    if (ain !== 16'h0 || bin !== 16'h01E0) begin
      n_err++; $display("FAIL shl_operands got %h/%h want 0000/01e0", ain, bin);
    end
    do_cmd(3'd0, 3'd3, 2'b10, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0, 3'd0, 16'h0,
           lat, ain, bin, ea, eb, stb, r1, r2);
    n_vec++;
    if (bin !== 16'h0078) begin n_err++; $display("FAIL lsr_bin got %h want 0078", bin); end
  endtask

  task automatic test_bypass();
    logic [15:0] want;
    want = BYP ? 16'hAAAA : 16'h0011;
    wr(3'd1, 16'h0011);
    do_cmd(3'd1, 3'd0, 2'b00, 1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, 0, 1'b1, 3'd1, 16'hAAAA,
           lat, ain, bin, ea, eb, stb, r1, r2);
    n_vec++;
    if (ain !== want) begin n_err++; $display("FAIL rdA_write_same_reg got %h want %h", ain, want); end
    n_vec++;
    if (lat !== 2 || bin !== 16'h0042) begin
      n_err++; $display("FAIL rdA_bsel got lat %0d bin %h want 2/0042", lat, bin);
    end
    do_cmd(3'd1, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 0, 1'b0, 3'd0, 16'h0,
           lat, ain, bin, ea, eb, stb, r1, r2);
    n_vec++;
    if (ain !== 16'hAAAA || bin !== 16'hAAAA) begin
      n_err++; $display("FAIL write_committed got %h/%h want aaaa/aaaa", ain, bin);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    wr(3'd4, 16'h4444);
    do_cmd(3'd4, 3'd4, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 0, 1'b0, 3'd0, 16'h0,
           lat, ain, bin, ea, eb, stb, r1, r2);
    ifc.start = 1'b1;
    ifc.asel  = 1'b1;
    ifc.bsel  = 1'b0;
    ifc.rm    = 3'd4;
    tick();
    ifc.start = 1'b0;
    rst_n     = 1'b0;
    ifc.write = 1'b1;
    ifc.wnum  = 3'd6;
    ifc.wdata = 16'h6666;
    tick();
    rst_n     = 1'b1;
    ifc.write = 1'b0;
    n_vec++;
    if (ifc.ready !== 1'b1 || ifc.valid !== 1'b0) begin
      n_err++; $display("FAIL abort_handshake got ready %b valid %b want 1/0", ifc.ready, ifc.valid);
    end
    n_vec++;
    if (ifc.ain !== 16'h0 || ifc.bin !== 16'h0) begin
      n_err++; $display("FAIL abort_operands got %h/%h want 0000/0000", ifc.ain, ifc.bin);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ifc.valid) saw_valid = 1'b1;
    end
    n_vec++;
    if (saw_valid) begin n_err++; $display("FAIL abort_no_valid got 1 want 0"); end
    for (int i = 0; i < 8; i += 2) begin
      do_cmd(3'(i), 3'(i + 1), 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 0, 1'b0, 3'd0, 16'h0,
             lat, ain, bin, ea, eb, stb, r1, r2);
      n_vec++;
      if (ain !== 16'h0 || bin !== 16'h0) begin
        n_err++; $display("FAIL abort_regs R%0d/R%0d got %h/%h want 0000/0000", i, i + 1, ain, bin);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  rn, rm;
    logic [1:0]  sh;
    logic        as, bs;
    logic [15:0] imm;
    int          elat;
    for (int i = 0; i < 8; i++) wr(3'(i), 16'($urandom));
    for (int k = 0; k < 60; k++) begin
      rn  = 3'($urandom);
      rm  = 3'($urandom);
      sh  = 2'($urandom);
      as  = ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 3) == 0);
      imm = 16'($urandom);
      elat = 1 + (as ? 0 : 1) + (bs ? 0 : 1);
      do_cmd(rn, rm, sh, as, bs, imm, 1'b1, 1'($urandom), -1, 1'b0, 3'd0, 16'h0,
             lat, ain, bin, ea, eb, stb, r1, r2);
      n_vec++;
      if (lat !== elat || ain !== ea || bin !== eb) begin
        n_err++;
        $display("FAIL rand%0d rn%0d rm%0d sh%0d as%b bs%b got lat %0d %h/%h want lat %0d %h/%h",
                 k, rn, rm, sh, as, bs, lat, ain, bin, elat, ea, eb);
      end
      n_vec++;
      if (!stb || r1 !== 1'b1 || r2 !== 1'b1) begin
        n_err++; $display("FAIL rand%0d_handshake got stable %b ready %b%b want 1/11", k, stb, r1, r2);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
    idle_inputs();
    test_reset();
    test_full_read();
    test_imm_only();
    test_shift();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Upstream operand stage of the datapath: holds the 8×16 general-purpose register file and builds the two 16-bit ALU operands from it. A `start` command reads up to two registers sequentially through a single read port, shifts the second operand, and applies the immediate/zero operand selects. It then presents `Ain`/`Bin` under a valid/accept handshake to the ALU stage, whose result comes back through the write port.

## Interface
- `N`, default 16: datapath width.
- `NREG`, default 8: register count. The address width is log2(NREG) = 3.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  command strobe; taken only when `ready`=1.
- `ready`  out  1  high exactly in IDLE.
- `rn`, `rm`  in  3  register numbers for operand A and operand B.
- `shift`  in  2  B shift op: 00 none, 01 shl1 (fill 0), 10 lsr1 (fill 0), 11 asr1 (fill B[15]).
- `asel`  in  1  1: Ain=0, and no A read.
- `bsel`  in  1  1: Bin=`sximm5`, and no B read.
- `sximm5`  in  N  sign-extended immediate.
- `write`, `wnum`, `wdata`  in  1/3/N  register-file write port (writeback).
- `valid`  out  1  operands presented.
- `accept`  in  1  ALU stage consumes the operands.
- `Ain`, `Bin`  out  N  registered operands to the ALU.

## Operation
- States: IDLE, RD_A, RD_B, HOLD.
- IDLE with `start`=1:
  - Captures `rn`, `rm`, `shift`, `asel`, `bsel`, `sximm5` into command registers.
  - Next state is RD_A if `asel`=0; else RD_B if `bsel`=0; else HOLD.
- RD_A: A ← R[rn]. Next state is RD_B if `bsel`=0, else HOLD.
- RD_B: B ← shift(R[rm]). Next state is HOLD.
- HOLD:
  - `valid`=1.
  - `Ain` = `asel` ? 0 : A.
  - `Bin` = `bsel` ? `sximm5` : B. The immediate is not shifted.
  - `valid`&&`accept` returns to IDLE.
- Inputs outside their capture state are ignored:
  - `start` when not in IDLE, including a `start` in the same cycle as `accept`.
  - `accept` when not in HOLD.
- Write port:
  - Independent of the FSM and active in every state.
  - `write`=1 stores `wdata` into R[wnum] at the edge.
- Read/write same register in the same cycle, with bypass off: the read returns the old value.
- Shifts drop the shifted-out bit. No carry or flag is produced.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - R0–R7, A, B, command registers, `Ain` and `Bin` all clear to 0.
  - `valid`=0, `ready`=1.
  - `start` and `write` are ignored during that cycle.
- Reset during RD_A, RD_B or HOLD aborts the command. No `valid` pulse follows.
- Latency from `start` edge to `valid`=1:
  - 3 cycles for a full read.
  - 2 cycles when one read is skipped.
  - 1 cycle when `asel`=`bsel`=1.
- `Ain`, `Bin` and `valid` are driven from registers or decoded state only. They stay stable throughout HOLD until accepted.
- After acceptance, `ready`=1 on the next cycle. Back-to-back commands have a minimum period of latency+1 cycles.

## Configuration
- `OPERAND_FETCH_BYPASS_EN` defined:
  - In RD_A/RD_B, if `write`=1 and `wnum` equals the register being read, the stage loads `wdata` instead of the stored value.
  - The write still commits.
- Not defined: the stage reads the pre-write value, and software must separate the write and the read by one cycle.

## Structure
- Package `operand_pkg` contains:
  - `N`, `NREG` and the register-address width.
  - The state enum (IDLE, RD_A, RD_B, HOLD).
  - The shift-op enum (SH_NONE, SH_LSL, SH_LSR, SH_ASR).
- Sub-module `reg_file`: NREG×N array, one combinational read port, one synchronous write port, synchronous reset. The bypass mux lives inside it under the macro.
- The shifter, selects and FSM live in `operand_fetch`.

## Test plan
- Reset, write R2=0x1234 and R5=0x8001, then start with rn=2, rm=5, shift=11, asel=bsel=0 → `valid` 3 cycles later, Ain=0x1234, Bin=0xC000. Hold `accept`=0 for 4 cycles: outputs stable.
- Start with asel=1, bsel=1, sximm5=0xFFFE → `valid` after 1 cycle, Ain=0x0000, Bin=0xFFFE. A `start` pulsed in the accept cycle is ignored: `ready`=1 the next cycle, no new capture.
- R3=0x00F0, shift=01 with rm=3, asel=1 → latency 2, Bin=0x01E0. With shift=10 → Bin=0x0078.
- Write R1=0xAAAA in the RD_A cycle of a read with rn=1 (old R1=0x0011) → Ain=0xAAAA with the macro defined, 0x0011 without it. R1 reads 0xAAAA afterwards in both builds.
- Drive `rst_n`=0 while in RD_B → next cycle state is IDLE, `valid`=0, `ready`=1, all registers read 0.
